// File: rtl/dp_pkg.sv
// -----------------------------------------------------------------------------
// dp_pkg
// Shared definitions for the datapath result interface.
//   DP_ZWIDTH / DP_XWIDTH : default widths of the signed z and x results
//   DP_DEPTH              : default result FIFO depth
//   dp_result_t           : one (z, x) result pair as carried through the FIFO
// -----------------------------------------------------------------------------
package dp_pkg;

    localparam int DP_ZWIDTH = 8;
    localparam int DP_XWIDTH = 16;
    localparam int DP_DEPTH  = 8;

    typedef struct packed {
        logic signed [DP_ZWIDTH-1:0] z;
        logic signed [DP_XWIDTH-1:0] x;
    } dp_result_t;

endpackage : dp_pkg

// File: rtl/dp_scomp.sv
// -----------------------------------------------------------------------------
// dp_scomp
// Signed magnitude comparator, two's complement at DATAWIDTH bits.
//   a, b : operands (interpreted as signed)
//   lt   : a <  b
//   gt   : a >  b
// -----------------------------------------------------------------------------
module dp_scomp #(
    parameter int DATAWIDTH = 16
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 lt,
    output logic                 gt
);

    assign lt = ($signed(a) < $signed(b));
    assign gt = ($signed(a) > $signed(b));

endmodule : dp_scomp

// File: rtl/dp_sync_fifo.sv
// -----------------------------------------------------------------------------
// dp_sync_fifo
// Single-clock FIFO with a registered head-of-queue output.
//   clk, rst : clock, synchronous active-high reset
//   push     : write wdata (ignored when full unless a pop happens too)
//   wdata    : data to enqueue
//   pop      : consume the head entry (ignored when empty)
//   rdata    : registered head entry, valid whenever !empty
//   empty    : no entries
//   full     : DEPTH entries
//   level    : occupancy 0..DEPTH
// A word pushed into an empty FIFO shows on rdata the next cycle; there is no
// combinational bypass from wdata to rdata.
// -----------------------------------------------------------------------------
module dp_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    rd_ptr_next;
    logic [LW-1:0]    level_reg;
    logic [WIDTH-1:0] rdata_reg;

    logic do_push;
    logic do_pop;
    logic head_from_wdata;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == FULL_LVL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rd_ptr_next = do_pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

    // The word being written becomes the new head only when nothing else is
    // left in front of it after this cycle's pop. In that case the write
    // pointer equals the next read pointer (a full FIFO with push+pop never
    // aliases here because the read pointer has already moved on).
    assign head_from_wdata = do_push && (wr_ptr_reg == rd_ptr_next);

    // Storage array: no reset so it maps onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            rdata_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;

            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase

            // Registered head: refresh on a new head, hold otherwise.
            if (head_from_wdata) begin
                rdata_reg <= wdata;
            end else if (do_pop) begin
                rdata_reg <= mem[rd_ptr_next];
            end
        end
    end

    assign rdata = rdata_reg;
    assign level = level_reg;

endmodule : dp_sync_fifo

// File: rtl/dp_result_sink.sv
// -----------------------------------------------------------------------------
// dp_result_sink
// Reader side of a datapath's registered (z, x) result interface.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_z/in_x: result pair from the producer (no backpressure)
//   out_valid/out_ready/out_z/out_x : head-of-FIFO handshake to the consumer
//   level             : FIFO occupancy 0..DEPTH
//   ovf               : sticky, a pair was dropped because the FIFO was full
//   clear_stats       : clears ovf and the x statistics (not the FIFO)
//   stats_valid       : at least one pair accepted since reset/clear
//   x_min / x_max     : signed running min/max of accepted x
// -----------------------------------------------------------------------------
module dp_result_sink
    import dp_pkg::*;
#(
    parameter int ZWIDTH = DP_ZWIDTH,
    parameter int XWIDTH = DP_XWIDTH,
    parameter int DEPTH  = DP_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [ZWIDTH-1:0]        in_z,
    input  logic [XWIDTH-1:0]        in_x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ZWIDTH-1:0]        out_z,
    output logic [XWIDTH-1:0]        out_x,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     clear_stats,
    output logic                     stats_valid,
    output logic [XWIDTH-1:0]        x_min,
    output logic [XWIDTH-1:0]        x_max
);

    localparam int W = ZWIDTH + XWIDTH;

    logic [W-1:0] fifo_rdata;
    logic         fifo_empty;
    logic         fifo_full;
    logic         push;
    logic         pop;
    logic         drop;

    logic              ovf_reg;
    logic              stats_valid_reg;
    logic [XWIDTH-1:0] x_min_reg;
    logic [XWIDTH-1:0] x_max_reg;
    logic              x_below_min;
    logic              x_above_max;

    // A full FIFO still accepts a pair when the head leaves in the same cycle.
    assign pop  = out_valid && out_ready;
    assign push = in_valid && (!fifo_full || pop);
    assign drop = in_valid && !push;

    dp_sync_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({in_z, in_x}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

    assign out_valid = !fifo_empty;
    assign out_z     = fifo_rdata[W-1:XWIDTH];
    assign out_x     = fifo_rdata[XWIDTH-1:0];

    dp_scomp #(.DATAWIDTH(XWIDTH)) u_cmp_min (
        .a  (in_x),
        .b  (x_min_reg),
        .lt (x_below_min),
        .gt ()
    );

    dp_scomp #(.DATAWIDTH(XWIDTH)) u_cmp_max (
        .a  (in_x),
        .b  (x_max_reg),
        .lt (),
        .gt (x_above_max)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg         <= 1'b0;
            stats_valid_reg <= 1'b0;
            x_min_reg       <= '0;
            x_max_reg       <= '0;
        end else if (clear_stats) begin
            // Clear beats a simultaneous drop; a simultaneous accepted push
            // restarts the statistics from that pair.
            ovf_reg         <= 1'b0;
            stats_valid_reg <= push;
            x_min_reg       <= push ? in_x : '0;
            x_max_reg       <= push ? in_x : '0;
        end else begin
            if (drop) begin
                ovf_reg <= 1'b1;
            end
            if (push) begin
                stats_valid_reg <= 1'b1;
                if (!stats_valid_reg) begin
                    x_min_reg <= in_x;
                    x_max_reg <= in_x;
                end else begin
                    if (x_below_min) begin
                        x_min_reg <= in_x;
                    end
                    if (x_above_max) begin
                        x_max_reg <= in_x;
                    end
                end
            end
        end
    end

    assign ovf         = ovf_reg;
    assign stats_valid = stats_valid_reg;
    assign x_min       = x_min_reg;
    assign x_max       = x_max_reg;

endmodule : dp_result_sink

// File: tb/tb_dp_result_sink.sv
module tb_dp_result_sink;
    import dp_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_z;
    logic [15:0] in_x;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_z;
    logic [15:0] out_x;
    logic [3:0]  level;
    logic        ovf;
    logic        clear_stats;
    logic        stats_valid;
    logic [15:0] x_min;
    logic [15:0] x_max;

    dp_result_sink #(.ZWIDTH(8), .XWIDTH(16), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_z        (in_z),
        .in_x        (in_x),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_z       (out_z),
        .out_x       (out_x),
        .level       (level),
        .ovf         (ovf),
        .clear_stats (clear_stats),
        .stats_valid (stats_valid),
        .x_min       (x_min),
        .x_max       (x_max)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of pairs plus scalar statistics.
    dp_result_t mq[$];
    int m_ovf, m_sv, m_min, m_max;

    typedef struct {
        logic        v;
        logic [7:0]  z;
        logic [15:0] x;
        logic        rdy;
        logic        clr;
        logic        rs;
        int          e_valid;
        int          e_z;
        int          e_x;
        int          e_lvl;
        int          e_ovf;
        int          e_sv;
        int          e_min;
        int          e_max;
        bit          chk_data;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] z, input logic [15:0] x,
                         input logic r, input logic c, input logic s);
        in_valid    = v;
        in_z        = z;
        in_x        = x;
        out_ready   = r;
        clear_stats = c;
        rst         = s;
    endtask

    task automatic model_step();
        int pop;
        int acc;
        int xi;
        dp_result_t r;
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_sv = 0; m_min = 0; m_max = 0;
            return;
        end
        xi  = $signed(in_x);
        pop = (mq.size() > 0 && out_ready) ? 1 : 0;
        acc = (in_valid && (mq.size() < DEPTH || pop != 0)) ? 1 : 0;
        if (pop != 0) void'(mq.pop_front());
        if (acc != 0) begin
            r.z = in_z;
            r.x = in_x;
            mq.push_back(r);
        end
        if (clear_stats) begin
            m_ovf = 0;
            m_sv  = acc;
            m_min = (acc != 0) ? xi : 0;
            m_max = (acc != 0) ? xi : 0;
        end else begin
            if (in_valid && acc == 0) m_ovf = 1;
            if (acc != 0) begin
                if (m_sv == 0) begin
                    m_sv = 1; m_min = xi; m_max = xi;
                end else begin
                    if (xi < m_min) m_min = xi;
                    if (xi > m_max) m_max = xi;
                end
            end
        end
    endtask

    // One clock: DUT and model both advance, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".valid"}, out_valid, (mq.size() > 0) ? 1 : 0);
        chk({tag, ".level"}, level, mq.size());
        chk({tag, ".ovf"}, ovf, m_ovf);
        chk({tag, ".stats_valid"}, stats_valid, m_sv);
        chk({tag, ".x_min"}, $signed(x_min), m_min);
        chk({tag, ".x_max"}, $signed(x_max), m_max);
        if (mq.size() > 0) begin
            chk({tag, ".out_z"}, $signed(out_z), mq[0].z);
            chk({tag, ".out_x"}, $signed(out_x), mq[0].x);
        end
    endtask

    initial begin
        //             v  z       x               rdy  clr  rs    val z   x       lvl ovf sv min     max    data
        tbl[0] = '{1'b1, 8'd5,  16'(-300),   1'b0, 1'b0, 1'b0, 1, 5, -300,   1, 0, 1, -300,   -300,  1'b1};
        tbl[1] = '{1'b1, 8'd1,  16'd100,     1'b1, 1'b0, 1'b0, 1, 1, 100,    1, 0, 1, -300,   100,   1'b1};
        tbl[2] = '{1'b1, 8'd2,  16'h8000,    1'b0, 1'b0, 1'b0, 1, 1, 100,    2, 0, 1, -32768, 100,   1'b1};
        tbl[3] = '{1'b1, 8'd3,  16'h7FFF,    1'b0, 1'b0, 1'b0, 1, 1, 100,    3, 0, 1, -32768, 32767, 1'b1};
        tbl[4] = '{1'b0, 8'd0,  16'd0,       1'b1, 1'b0, 1'b0, 1, 2, -32768, 2, 0, 1, -32768, 32767, 1'b1};
        tbl[5] = '{1'b0, 8'd0,  16'd0,       1'b1, 1'b0, 1'b0, 1, 3, 32767,  1, 0, 1, -32768, 32767, 1'b1};
        tbl[6] = '{1'b0, 8'd0,  16'd0,       1'b1, 1'b0, 1'b0, 0, 0, 0,      0, 0, 1, -32768, 32767, 1'b0};
        tbl[7] = '{1'b1, 8'd9,  16'd7,       1'b0, 1'b1, 1'b0, 1, 9, 7,      1, 0, 1, 7,      7,     1'b1};
        tbl[8] = '{1'b0, 8'd0,  16'd0,       1'b0, 1'b0, 1'b1, 0, 0, 0,      0, 0, 0, 0,      0,     1'b1};

        // Reset
        drive(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        step();
        step();
        chk("reset.valid", out_valid, 0);
        chk("reset.level", level, 0);
        chk("reset.ovf", ovf, 0);
        chk("reset.stats_valid", stats_valid, 0);
        chk("reset.x_min", $signed(x_min), 0);
        chk("reset.x_max", $signed(x_max), 0);
        chk("reset.out_z", out_z, 0);
        chk("reset.out_x", out_x, 0);
        drive(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0);

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v, tbl[i].z, tbl[i].x, tbl[i].rdy, tbl[i].clr, tbl[i].rs);
            step();
            chk($sformatf("vec%0d.valid", i), out_valid, tbl[i].e_valid);
            chk($sformatf("vec%0d.level", i), level, tbl[i].e_lvl);
            chk($sformatf("vec%0d.ovf", i), ovf, tbl[i].e_ovf);
            chk($sformatf("vec%0d.stats_valid", i), stats_valid, tbl[i].e_sv);
            chk($sformatf("vec%0d.x_min", i), $signed(x_min), tbl[i].e_min);
            chk($sformatf("vec%0d.x_max", i), $signed(x_max), tbl[i].e_max);
            if (tbl[i].chk_data) begin
                chk($sformatf("vec%0d.out_z", i), $signed(out_z), tbl[i].e_z);
                chk($sformatf("vec%0d.out_x", i), $signed(out_x), tbl[i].e_x);
            end
            $display("vec%0d: v=%0b z=%0d x=%0d rdy=%0b clr=%0b rst=%0b -> valid=%0b lvl=%0d z=%0d x=%0d",
                     i, tbl[i].v, tbl[i].z, $signed(tbl[i].x), tbl[i].rdy, tbl[i].clr, tbl[i].rs,
                     out_valid, level, $signed(out_z), $signed(out_x));
        end
        drive(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0);

        // Overflow: 8 pushes fill the FIFO, the 9th is dropped.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(i + 1), 16'(i * 100 - 400), 1'b0, 1'b0, 1'b0);
            step();
            compare_model("fill");
        end
        drive(1'b1, 8'd99, 16'd999, 1'b0, 1'b0, 1'b0);
        step();
        chk("drop.ovf", ovf, 1);
        chk("drop.level", level, 8);
        compare_model("drop");
        $display("drop: ovf=%0b level=%0d", ovf, level);
        for (int i = 0; i < 8; i++) begin
            chk("drain1.head", out_z, i + 1);
            drive(1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0);
            step();
            compare_model("drain1");
        end
        chk("drain1.empty", out_valid, 0);

        // Clear ovf and stats (no push), then full with simultaneous push+pop.
        drive(1'b0, 8'd0, 16'd0, 1'b0, 1'b1, 1'b0);
        step();
        chk("clear.ovf", ovf, 0);
        chk("clear.stats_valid", stats_valid, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(11 + i), 16'(i * 3), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 8'd50, 16'd5000, 1'b1, 1'b0, 1'b0);
        step();
        chk("fullpp.ovf", ovf, 0);
        chk("fullpp.level", level, 8);
        compare_model("fullpp");
        $display("fullpp: ovf=%0b level=%0d head_z=%0d", ovf, level, out_z);
        for (int k = 0; k < 8; k++) begin
            chk("drain2.head", out_z, (k < 7) ? 12 + k : 50);
            drive(1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0);
            step();
        end
        chk("drain2.level", level, 0);

        // Reset with three pairs buffered.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(i), 16'(i), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        step();
        chk("midrst.valid", out_valid, 0);
        chk("midrst.level", level, 0);
        chk("midrst.stats_valid", stats_valid, 0);
        chk("midrst.ovf", ovf, 0);
        $display("midrst: valid=%0b level=%0d", out_valid, level);

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                  8'($urandom), 16'($urandom),
                  ($urandom_range(0, 9) < ((n / 100) % 2 == 0 ? 3 : 7)) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
            step();
            compare_model($sformatf("rand%0d", n));
        end
        $display("random: 800 cycles, final level=%0d ovf=%0b", level, ovf);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dp_result_sink
